rv32i_dmem_bridge: RTL

//  Sits directly downstream of the memory-access stage and turns its one-shot load/store request
//   (byte-lane-aligned store data, write mask, write enable) into a pipelined, Wishbone-style

---
 rtl/rv32i_dmem_bridge.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rv32i_dmem_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv32i_dmem_bridge : MEM-stage load/store request to pipelined Wishbone bridge
// Rev 1.0
// ----------------------------------------------------------------------------
module rv32i_dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        req_ready,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_stall,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] tmo_cnt, tmo_cnt_next;
  logic [1:0]    lane;
  logic          issue;
  logic          complete;
  logic          cmp_err;
  logic [31:0]   cmp_rdata;

  assign req_ready = (state == S_IDLE);
  assign stall     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= state_next;
      tmo_cnt <= tmo_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    tmo_cnt_next = tmo_cnt;
    issue        = 1'b0;
    complete     = 1'b0;
    cmp_err      = 1'b0;
    cmp_rdata    = '0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          // An empty-mask store has nothing to write: answer without a bus cycle.
          if (req_we && (req_wmask == 4'b0000)) begin
            complete = 1'b1;
          end else begin
            issue        = 1'b1;
            tmo_cnt_next = '0;
            state_next   = S_REQ;
          end
        end
      end
      S_REQ, S_WAIT: begin
        tmo_cnt_next = tmo_cnt + 1'b1;
        if (bus_ack || bus_err) begin
          complete = 1'b1;
          cmp_err  = bus_err;
          if (!bus_err && !bus_we)
            cmp_rdata = bus_rdata >> {lane, 3'b000};
        end else if (tmo_cnt_next == CW'(TIMEOUT_CYCLES)) begin
          complete = 1'b1;
          cmp_err  = 1'b1;
        end else if ((state == S_REQ) && !bus_stall) begin
          state_next = S_WAIT;
        end
        if (complete)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_cyc   <= 1'b0;
      bus_stb   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
      lane      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= complete;
      if (complete) begin
        rsp_rdata <= cmp_rdata;
        rsp_err   <= cmp_err;
      end
      if (issue) begin
        bus_cyc   <= 1'b1;
        bus_stb   <= 1'b1;
        bus_we    <= req_we;
        bus_addr  <= {req_addr[31:2], 2'b00};
        bus_sel   <= req_we ? req_wmask : 4'b1111;
        bus_wdata <= req_wdata;
        lane      <= req_addr[1:0];
      end else if (complete) begin
        bus_cyc <= 1'b0;
        bus_stb <= 1'b0;
      end else if (state_next == S_WAIT) begin
        bus_stb <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
